// File: rtl/out_uart_tx.sv
// ---------------------------------------------------------------------------
// out_uart_tx
//
// Serial transmitter for the 16-bit output register. Each word written with
// ld_outr is queued in a 4-deep FIFO and sent as two 8N1 UART frames, high
// byte first, LSB first within each byte. Every serial bit lasts CLK_DIV
// clock cycles.
//
// Ports
//   clk       in   system clock, rising edge
//   rst       in   synchronous active-high reset
//   ld_outr   in   write strobe (same strobe that loads out_reg)
//   ra[15:0]  in   word to queue, sampled when ld_outr=1
//   txd       out  registered serial line, idles high
//   busy      out  FIFO non-empty or frame in progress
//   full      out  FIFO holds 4 words
//   overflow  out  sticky: a write was dropped because the FIFO was full
// ---------------------------------------------------------------------------
module out_uart_tx #(
   parameter int CLK_DIV = 434
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ld_outr,
   input  logic [15:0] ra,
   output logic        txd,
   output logic        busy,
   output logic        full,
   output logic        overflow
);

   localparam int BW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [BW-1:0] BAUD_LAST = BW'(CLK_DIV - 1);
   localparam logic [BW-1:0] BAUD_ONE  = BW'(1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;

   // ------------------------------------------------------------------
   // Storage and state
   // ------------------------------------------------------------------
   logic [15:0]   r_mem [0:3];
   logic [1:0]    r_wptr;
   logic [1:0]    r_rptr;
   logic [2:0]    r_count;
   logic          r_overflow;

   state_t        r_state;
   logic          r_hi_lo;
   logic [2:0]    r_bit_idx;
   logic [BW-1:0] r_baud;
   logic [15:0]   r_shift;
   logic          r_txd;

   logic          w_pop;
   logic          w_push;
   logic          w_drop;
   logic          w_baud_end;
   logic [7:0]    w_byte;

   // The FSM pops the head word on the same edge it leaves IDLE.
   assign w_pop  = (r_state == IDLE) && (r_count != 3'd0);

   // A full FIFO still accepts a write when a pop frees a slot that edge.
   assign w_push = ld_outr && ((r_count != 3'd4) || w_pop);
   assign w_drop = ld_outr && (r_count == 3'd4) && !w_pop;

   assign w_baud_end = (r_baud == BAUD_LAST);

   // Byte currently on the line: hi_lo=1 selects the high byte.
   generate
      for (genvar gi = 0; gi < 8; gi++) begin : g_byte_sel
         assign w_byte[gi] = r_hi_lo ? r_shift[8 + gi] : r_shift[gi];
      end
   endgenerate

   // ------------------------------------------------------------------
   // FIFO storage: no reset so it maps onto distributed/block RAM. Writes
   // during reset are suppressed so an ignored strobe leaves no trace.
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (w_push && !rst) begin
         r_mem[r_wptr] <= ra;
      end
   end

   // ------------------------------------------------------------------
   // FIFO pointers, occupancy and sticky overflow
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wptr     <= 2'd0;
         r_rptr     <= 2'd0;
         r_count    <= 3'd0;
         r_overflow <= 1'b0;
      end else begin
         if (w_push) begin
            r_wptr <= r_wptr + 2'd1;
         end
         if (w_pop) begin
            r_rptr <= r_rptr + 2'd1;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 3'd1;
            2'b01:   r_count <= r_count - 3'd1;
            default: r_count <= r_count;
         endcase
         if (w_drop) begin
            r_overflow <= 1'b1;
         end
      end
   end

   // ------------------------------------------------------------------
   // Transmit FSM. Every state lasts CLK_DIV cycles; txd is registered and
   // takes the value of the state being entered on the transition edge.
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= IDLE;
         r_hi_lo   <= 1'b0;
         r_bit_idx <= 3'd0;
         r_baud    <= '0;
         r_shift   <= 16'd0;
         r_txd     <= 1'b1;
      end else begin
         case (r_state)
            IDLE: begin
               r_baud <= '0;
               r_txd  <= 1'b1;
               if (w_pop) begin
                  r_shift <= r_mem[r_rptr];
                  r_hi_lo <= 1'b1;
                  r_state <= START;
                  r_txd   <= 1'b0;
               end
            end

            START: begin
               if (w_baud_end) begin
                  r_baud    <= '0;
                  r_bit_idx <= 3'd0;
                  r_state   <= DATA;
                  r_txd     <= w_byte[0];
               end else begin
                  r_baud <= r_baud + BAUD_ONE;
               end
            end

            DATA: begin
               if (w_baud_end) begin
                  r_baud <= '0;
                  if (r_bit_idx == 3'd7) begin
                     r_state <= STOP;
                     r_txd   <= 1'b1;
                  end else begin
                     r_bit_idx <= r_bit_idx + 3'd1;
                     r_txd     <= w_byte[r_bit_idx + 3'd1];
                  end
               end else begin
                  r_baud <= r_baud + BAUD_ONE;
               end
            end

            STOP: begin
               if (w_baud_end) begin
                  r_baud <= '0;
                  if (r_hi_lo) begin
                     // High byte done: second frame follows with no gap.
                     r_hi_lo <= 1'b0;
                     r_state <= START;
                     r_txd   <= 1'b0;
                  end else begin
                     // Passing through IDLE gives the 1-cycle gap between words.
                     r_state <= IDLE;
                     r_txd   <= 1'b1;
                  end
               end else begin
                  r_baud <= r_baud + BAUD_ONE;
               end
            end

            default: begin
               r_state <= IDLE;
               r_baud  <= '0;
               r_txd   <= 1'b1;
            end
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   assign txd      = r_txd;
   assign busy     = (r_state != IDLE) || (r_count != 3'd0);
   assign full     = (r_count == 3'd4);
   assign overflow = r_overflow;

endmodule

// File: tb/tb_out_uart_tx.sv
module tb_out_uart_tx;

   localparam int DIV   = 4;
   localparam int FRAME = 20 * DIV;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        ld_outr = 1'b0;
   logic [15:0] ra = 16'd0;
   logic        txd, busy, full, overflow;

   always #5 clk = ~clk;

   out_uart_tx #(.CLK_DIV(DIV)) dut (
      .clk      (clk),
      .rst      (rst),
      .ld_outr  (ld_outr),
      .ra       (ra),
      .txd      (txd),
      .busy     (busy),
      .full     (full),
      .overflow (overflow)
   );

   int n_checks = 0;
   int n_errors = 0;
   int n_frames = 0;

   task automatic chk(input string tag, input logic [79:0] got, input logic [79:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Line waveform of one word, one entry per clock: 20 bits of DIV cycles.
   function automatic logic [79:0] exp_frame(input logic [15:0] w);
      logic [19:0] b;
      logic [79:0] f;
      b[0]  = 1'b0;
      for (int i = 0; i < 8; i++) b[1 + i] = w[8 + i];
      b[9]  = 1'b1;
      b[10] = 1'b0;
      for (int i = 0; i < 8; i++) b[11 + i] = w[i];
      b[19] = 1'b1;
      for (int s = 0; s < FRAME; s++) f[s] = b[s / DIV];
      return f;
   endfunction

   // ---------------------------------------------------------------
   // Reference model: a word queue plus a transmitter that, once it takes
   // a word, is occupied for FRAME cycles and can take the next one on
   // the edge after that.
   // ---------------------------------------------------------------
   logic [15:0] m_fifo[$];
   logic [15:0] m_sent[$];
   int          m_left = 0;
   bit          m_ovf = 1'b0;

   initial begin
      forever begin
         bit pop_e, push_e;
         @(posedge clk);
         if (rst) begin
            m_fifo.delete();
            m_sent.delete();
            m_left = 0;
            m_ovf  = 1'b0;
         end else begin
            pop_e  = (m_left == 0) && (m_fifo.size() > 0);
            if (m_left > 0) m_left--;
            push_e = ld_outr && ((m_fifo.size() < 4) || pop_e);
            if (ld_outr && !push_e) m_ovf = 1'b1;
            if (pop_e) begin
               m_sent.push_back(m_fifo.pop_front());
               m_left = FRAME;
            end
            if (push_e) m_fifo.push_back(ra);
         end
      end
   end

   // ---------------------------------------------------------------
   // Monitor: flag comparison every cycle, frame capture on txd falling.
   // ---------------------------------------------------------------
   int          mcnt = 0;
   bit          gap_pending = 1'b0;
   logic        prev_txd = 1'b1;
   logic [79:0] obs;

   initial begin
      forever begin
         logic [15:0] w;
         logic        m_busy, m_full;
         @(posedge clk);
         #2;
         m_busy = (m_left > 0) || (m_fifo.size() > 0);
         m_full = (m_fifo.size() == 4);
         chk("flags{busy,full,ovf}", {77'd0, busy, full, overflow},
             {77'd0, m_busy, m_full, m_ovf});
         if (gap_pending) begin
            chk("idle gap", {79'd0, txd}, 80'd1);
            gap_pending = 1'b0;
         end else if (mcnt > 0) begin
            obs[mcnt] = txd;
            mcnt++;
            if (mcnt == FRAME) begin
               chk("frame queued", {79'd0, (m_sent.size() > 0)}, 80'd1);
               if (m_sent.size() > 0) begin
                  w = m_sent.pop_front();
                  chk("frame", obs, exp_frame(w));
                  n_frames++;
                  $display("frame %0d: word %h", n_frames, w);
               end
               mcnt = 0;
               gap_pending = 1'b1;
            end
         end else if (prev_txd && !txd) begin
            obs[0] = txd;
            mcnt = 1;
         end
         prev_txd = txd;
         if (rst) begin
            mcnt = 0;
            gap_pending = 1'b0;
            prev_txd = 1'b1;
         end
      end
   end

   // ---------------------------------------------------------------
   // Driver helpers
   // ---------------------------------------------------------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic write_word(input logic [15:0] w);
      ld_outr = 1'b1;
      ra      = w;
      tick();
      ld_outr = 1'b0;
      ra      = 16'($urandom);
   endtask

   task automatic wait_quiet(input int bound);
      int k = 0;
      while ((m_left > 0 || m_fifo.size() > 0 || mcnt > 0 || gap_pending) && k < bound) begin
         tick();
         k++;
      end
      chk("quiet within bound", {79'd0, (k < bound)}, 80'd1);
      tick();
   endtask

   task automatic wait_left(input int v, input bit need_full, input int bound);
      int k = 0;
      while (!(m_left == v && (!need_full || m_fifo.size() == 4)) && k < bound) begin
         tick();
         k++;
      end
      chk("sync within bound", {79'd0, (k < bound)}, 80'd1);
   endtask

   initial begin
      #600000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------------------------------------------------------
   // Stimulus
   // ---------------------------------------------------------------
   initial begin
      int          pat_a[20] = '{0,0,1,0,0,1,0,0,0,1, 0,1,0,1,0,0,1,0,1,1};
      logic [19:0] pat;
      logic [19:0] got;
      logic [15:0] w;
      bit          stayed;

      // Reset, with a strobe that must be ignored.
      rst = 1'b1;
      tick();
      ld_outr = 1'b1;
      ra = 16'hDEAD;
      tick();
      ld_outr = 1'b0;
      tick();
      chk("reset txd", {79'd0, txd}, 80'd1);
      chk("reset busy", {79'd0, busy}, 80'd0);
      chk("reset full", {79'd0, full}, 80'd0);
      chk("reset overflow", {79'd0, overflow}, 80'd0);
      rst = 1'b0;
      tick();
      chk("strobe during reset ignored", {79'd0, busy}, 80'd0);

      // Single word 0x12A5: latency and exact bit sequence.
      for (int i = 0; i < 20; i++) pat[i] = pat_a[i][0];
      ld_outr = 1'b1;
      ra = 16'h12A5;
      tick();
      ld_outr = 1'b0;
      ra = 16'hFFFF;
      chk("latency edge N", {79'd0, txd}, 80'd1);
      tick();
      chk("latency edge N+1", {79'd0, txd}, 80'd0);
      for (int s = 0; s < FRAME; s++) begin
         if (s % DIV == DIV / 2) got[s / DIV] = txd;
         tick();
      end
      chk("0x12A5 bit sequence", {60'd0, got}, {60'd0, pat});
      chk("busy low after stop", {79'd0, busy}, 80'd0);
      wait_quiet(200);

      // FIFO fill with five back-to-back writes.
      for (int i = 1; i <= 5; i++) write_word(16'(i));
      chk("fill overflow", {79'd0, overflow}, 80'd0);

      // Simultaneous push and pop with four queued.
      wait_left(0, 1'b1, 300);
      write_word(16'h5A5A);
      chk("push+pop full", {79'd0, full}, 80'd1);
      chk("push+pop overflow", {79'd0, overflow}, 80'd0);

      // Overflow: frame in progress and four queued.
      write_word(16'hBEEF);
      chk("overflow set", {79'd0, overflow}, 80'd1);
      wait_quiet(3000);
      chk("overflow sticky", {79'd0, overflow}, 80'd1);

      // Reset during high-byte data bit 3 with two words queued.
      write_word(16'hA1B2);
      write_word(16'hC3D4);
      write_word(16'hE5F6);
      wait_left(FRAME - 17, 1'b0, 200);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("mid-frame reset txd", {79'd0, txd}, 80'd1);
      chk("mid-frame reset busy", {79'd0, busy}, 80'd0);
      chk("mid-frame reset full", {79'd0, full}, 80'd0);
      chk("mid-frame reset overflow", {79'd0, overflow}, 80'd0);
      stayed = 1'b1;
      for (int i = 0; i < 3 * FRAME; i++) begin
         if (txd !== 1'b1) stayed = 1'b0;
         tick();
      end
      chk("line idle after reset", {79'd0, stayed}, 80'd1);
      write_word(16'h3C3C);
      wait_quiet(300);

      // Ten distinct words, one at a time, across pointer wrap.
      for (int i = 0; i < 10; i++) begin
         w = {12'($urandom), 4'(i)};
         write_word(w);
         wait_quiet(300);
      end

      // Random traffic with occasional resets.
      for (int i = 0; i < 600; i++) begin
         ld_outr = ($urandom_range(0, 9) < 2);
         ra      = 16'($urandom);
         rst     = ($urandom_range(0, 299) == 0);
         tick();
      end
      ld_outr = 1'b0;
      rst = 1'b0;
      wait_quiet(3000);
      chk("all frames received", 80'(m_sent.size()), 80'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
